ahb_arbiter_param: RTL

- Parametrised AHB arbiter/master-select unit for the next-generation generated AHB bus.
- Replaces the fixed 4-master arbitration hard-wired into the current bus with an arbiter generalised over master count and priority width.
- Adds selectable fixed-priority / round-robin mode, burst-aware grant holding, locked-transfer support and a data-phase owner register.
- Feeds hmaster/hmaster_d to the bus address and data muxes.

---
 rtl/ahb_arbiter_param.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/ahb_arbiter_param.sv
// Parametrised AHB arbiter: fixed-priority or round-robin master select with
// burst-aware grant holding, locked sequences and a data-phase owner register.
module ahb_arbiter_param #(
  parameter int MasNum = 4,
  parameter int PrioW  = 2,
  parameter int DefMas = 0,
  parameter int IdxW   = $clog2(MasNum)
) (
  input  logic                      hclk,
  input  logic                      hreset_n,
  input  logic [MasNum-1:0]         hbusreq,
  input  logic [MasNum-1:0]         hlock,
  input  logic [MasNum*PrioW-1:0]   hprior,
  input  logic                      arb_mode,
  input  logic [1:0]                htrans,
  input  logic [2:0]                hburst,
  input  logic                      hready,
  output logic [MasNum-1:0]         hgrant,
  output logic [IdxW-1:0]           hmaster,
  output logic [IdxW-1:0]           hmaster_d,
  output logic                      hmastlock
);

  localparam logic [1:0] ST_ARB   = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_LOCK  = 2'd2;

  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  localparam logic [IdxW-1:0]   DEF_IDX   = IdxW'(DefMas);
  localparam logic [MasNum-1:0] DEF_GRANT = MasNum'(1) << DefMas;

  logic [1:0]        state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              lock_tail_reg, lock_tail_next;
  logic              hmastlock_reg, hmastlock_next;
  logic [MasNum-1:0] hgrant_reg;
  logic [IdxW-1:0]   hmaster_reg, hmaster_d_reg, rr_ptr_reg;
  logic              arbitrate;

  logic [PrioW-1:0]  prio [MasNum];
  logic              fixed_found, rr_found;
  logic [IdxW-1:0]   fixed_idx, rr_idx, winner;
  logic [PrioW-1:0]  fixed_pri;
  logic [MasNum-1:0] winner_onehot;
  logic [3:0]        burst_load;

  genvar gi;
  generate
    for (gi = 0; gi < MasNum; gi++) begin : g_prio
      assign prio[gi]          = hprior[gi*PrioW +: PrioW];
      assign winner_onehot[gi] = (winner == IdxW'(gi));
    end
  endgenerate

  // Upward scan with strict '>' keeps the lowest index on a priority tie.
  always_comb begin
    fixed_found = 1'b0;
    fixed_idx   = DEF_IDX;
    fixed_pri   = '0;
    for (int i = 0; i < MasNum; i++) begin
      if (hbusreq[i] && (!fixed_found || (prio[i] > fixed_pri))) begin
        fixed_found = 1'b1;
        fixed_idx   = IdxW'(i);
        fixed_pri   = prio[i];
      end
    end
  end

  // Round-robin scan from pointer+1 with wrap: indices above the pointer first,
  // then the wrapped part up to and including the pointer itself.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = DEF_IDX;
    for (int i = 0; i < MasNum; i++) begin
      if (!rr_found && hbusreq[i] && (IdxW'(i) > rr_ptr_reg)) begin
        rr_found = 1'b1;
        rr_idx   = IdxW'(i);
      end
    end
    for (int i = 0; i < MasNum; i++) begin
      if (!rr_found && hbusreq[i] && (IdxW'(i) <= rr_ptr_reg)) begin
        rr_found = 1'b1;
        rr_idx   = IdxW'(i);
      end
    end
  end

  always_comb begin
    if (hbusreq == '0) begin
      winner = DEF_IDX;
    end else if (arb_mode) begin
      winner = rr_idx;
    end else begin
      winner = fixed_idx;
    end
  end

  // Counter is loaded with len-2: the NONSEQ beat is consumed on the load edge
  // and the final SEQ beat is recognised by a zero count.
  always_comb begin
    case (hburst[2:1])
      2'b01:   burst_load = 4'd2;
      2'b10:   burst_load = 4'd6;
      default: burst_load = 4'd14;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    lock_tail_next = lock_tail_reg;
    hmastlock_next = hmastlock_reg;
    arbitrate      = 1'b0;
    case (state_reg)
      ST_ARB: begin
        if ((htrans == TR_NONSEQ) && (hburst >= 3'd2)) begin
          state_next = ST_BURST;
          cnt_next   = burst_load;
        end else if (hlock[hmaster_reg] && (htrans == TR_NONSEQ)) begin
          state_next     = ST_LOCK;
          hmastlock_next = 1'b1;
          lock_tail_next = 1'b0;
        end else begin
          arbitrate = 1'b1;
        end
      end
      ST_BURST: begin
        if (htrans == TR_SEQ) begin
          if (cnt_reg == 4'd0) begin
            state_next = ST_ARB;
            arbitrate  = 1'b1;
          end else begin
            cnt_next = cnt_reg - 4'd1;
          end
        end else if (htrans != TR_BUSY) begin
          // IDLE or NONSEQ terminates the burst early
          state_next = ST_ARB;
          arbitrate  = 1'b1;
        end
      end
      ST_LOCK: begin
        if (lock_tail_reg) begin
          state_next     = ST_ARB;
          hmastlock_next = 1'b0;
          lock_tail_next = 1'b0;
        end else if (!hlock[hmaster_reg]) begin
          lock_tail_next = 1'b1;
        end
      end
      default: begin
        state_next = ST_ARB;
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_reg     <= ST_ARB;
      cnt_reg       <= 4'd0;
      lock_tail_reg <= 1'b0;
      hmastlock_reg <= 1'b0;
      hgrant_reg    <= DEF_GRANT;
      hmaster_reg   <= DEF_IDX;
      hmaster_d_reg <= DEF_IDX;
      rr_ptr_reg    <= DEF_IDX;
    end else if (hready) begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      lock_tail_reg <= lock_tail_next;
      hmastlock_reg <= hmastlock_next;
      hmaster_d_reg <= hmaster_reg;
      if (arbitrate) begin
        hgrant_reg  <= winner_onehot;
        hmaster_reg <= winner;
        if ((winner != hmaster_reg) && hbusreq[winner]) begin
          rr_ptr_reg <= winner;
        end
      end
    end
  end

  assign hgrant    = hgrant_reg;
  assign hmaster   = hmaster_reg;
  assign hmaster_d = hmaster_d_reg;
  assign hmastlock = hmastlock_reg;

endmodule
